seq_controller: RTL and testbench

Multi-cycle sequencer for the Y86-64 SEQ datapath. It steps each instruction through fetch, decode, execute, memory, writeback and PC-update by asserting one stage enable per cycle, and stalls in memory until the data memory handshakes. It owns the architectural condition-code register (ZF/SF/OF), updated from the execute-stage ALU flags, and produces `cnd` for cmovXX/jXX. It also tracks processor status (AOK/HLT/ADR/INS) and keeps cycle and retired-instruction counters.

---
 rtl/seq_controller.sv | 165 ++++++++++++++++
 tb/tb_seq_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_controller.sv
// seq_controller: multi-cycle stage sequencer for the Y86-64 SEQ datapath.
// Walks each instruction through FETCH..PCUPD with one-hot stage enables,
// owns the condition codes and processor status, and counts cycles and
// retired instructions.
//
// Data-memory handshake: mem_req is held high for every MEMORY cycle of a
// memory instruction; the access completes in the cycle where mem_ready=1,
// and dmem_error is only meaningful in that same cycle.
module seq_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        dmem_error,
  input  logic        mem_ready,
  input  logic        e_zf,
  input  logic        e_sf,
  input  logic        e_of,
  output logic        f_en,
  output logic        d_en,
  output logic        e_en,
  output logic        m_en,
  output logic        w_en,
  output logic        pc_en,
  output logic        mem_req,
  output logic [2:0]  cc,
  output logic        cnd,
  output logic [1:0]  stat,
  output logic        busy,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] stat_nxt;
  logic       mem_op;
  logic       sf_xor_of;

  assign busy      = (state != S_IDLE) && (state != S_HALT);
  assign dbg_state = state;
  assign sf_xor_of = cc[1] ^ cc[0];

  // Instructions that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq.
  always_comb begin
    mem_op = 1'b0;
    case (icode)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: mem_op = 1'b1;
      default:                            mem_op = 1'b0;
    endcase
  end

  // Next-state and status decision; faults in FETCH are prioritised ADR > INS > HLT.
  always_comb begin
    state_nxt = state;
    stat_nxt  = stat;
    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_error) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_ADR;
        end else if (!instr_valid) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_INS;
        end else if (icode == 4'h0) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_HLT;
        end else begin
          state_nxt = S_DECODE;
        end
      end
      S_DECODE:  state_nxt = S_EXECUTE;
      S_EXECUTE: state_nxt = S_MEMORY;
      S_MEMORY: begin
        if (!mem_op) begin
          state_nxt = S_WRITEBACK;
        end else if (mem_ready) begin
          if (dmem_error) begin
            state_nxt = S_HALT;
            stat_nxt  = STAT_ADR;
          end else begin
            state_nxt = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: state_nxt = S_PCUPD;
      S_PCUPD:     state_nxt = run ? S_FETCH : S_IDLE;
      S_HALT:      state_nxt = S_HALT;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Registered FSM state, stage enables, condition codes, status and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      f_en        <= 1'b0;
      d_en        <= 1'b0;
      e_en        <= 1'b0;
      m_en        <= 1'b0;
      w_en        <= 1'b0;
      pc_en       <= 1'b0;
      mem_req     <= 1'b0;
      cc          <= 3'b100;
      stat        <= STAT_AOK;
      cycle_count <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      state   <= state_nxt;
      stat    <= stat_nxt;
      f_en    <= (state_nxt == S_FETCH);
      d_en    <= (state_nxt == S_DECODE);
      e_en    <= (state_nxt == S_EXECUTE);
      m_en    <= (state_nxt == S_MEMORY);
      w_en    <= (state_nxt == S_WRITEBACK);
      pc_en   <= (state_nxt == S_PCUPD);
      mem_req <= (state_nxt == S_MEMORY) && mem_op;
      // Only OPq writes the flags, so a later jXX/cmovXX sees them from MEMORY on.
      if ((state == S_EXECUTE) && (icode == 4'h6)) cc <= {e_zf, e_sf, e_of};
      if (busy) cycle_count <= cycle_count + 32'd1;
      if (state == S_PCUPD) instr_count <= instr_count + 32'd1;
    end
  end

  // Branch/move condition from the architectural flags, only for cmovXX and jXX.
  always_comb begin
    cnd = 1'b0;
    if ((icode == 4'h2) || (icode == 4'h7)) begin
      case (ifun)
        4'h0:    cnd = 1'b1;
        4'h1:    cnd = sf_xor_of | cc[2];
        4'h2:    cnd = sf_xor_of;
        4'h3:    cnd = cc[2];
        4'h4:    cnd = !cc[2];
        4'h5:    cnd = !sf_xor_of;
        4'h6:    cnd = !sf_xor_of && !cc[2];
        default: cnd = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: cycle-by-cycle vector bench for seq_controller.
module tb_seq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic        instr_valid;
  logic        imem_error;
  logic        dmem_error;
  logic        mem_ready;
  logic        e_zf, e_sf, e_of;
  logic        f_en, d_en, e_en, m_en, w_en, pc_en;
  logic        mem_req;
  logic [2:0]  cc;
  logic        cnd;
  logic [1:0]  stat;
  logic        busy;
  logic [31:0] cycle_count;
  logic [31:0] instr_count;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  localparam int S_I = 0, S_F = 1, S_D = 2, S_E = 3, S_M = 4, S_W = 5, S_P = 6, S_H = 7;

  typedef struct {
    logic       run;
    logic [3:0] icode;
    logic [3:0] ifun;
    logic       iv;
    logic       ierr;
    logic       derr;
    logic       mrdy;
    logic [2:0] ef;
    int         st;
    logic       mreq;
    logic [2:0] cc;
    logic       cnd;
    logic [1:0] stat;
  } vec_t;

  vec_t vq[$];

  seq_controller dut (
    .clk(clk), .rst(rst), .run(run), .icode(icode), .ifun(ifun),
    .instr_valid(instr_valid), .imem_error(imem_error),
    .dmem_error(dmem_error), .mem_ready(mem_ready),
    .e_zf(e_zf), .e_sf(e_sf), .e_of(e_of),
    .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en),
    .pc_en(pc_en), .mem_req(mem_req), .cc(cc), .cnd(cnd), .stat(stat),
    .busy(busy), .cycle_count(cycle_count), .instr_count(instr_count),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [5:0] en_of(input int st);
    case (st)
      S_F:     return 6'b100000;
      S_D:     return 6'b010000;
      S_E:     return 6'b001000;
      S_M:     return 6'b000100;
      S_W:     return 6'b000010;
      S_P:     return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    run = 1'b0; icode = 4'h0; ifun = 4'h0; instr_valid = 1'b1;
    imem_error = 1'b0; dmem_error = 1'b0; mem_ready = 1'b0;
    {e_zf, e_sf, e_of} = 3'b000;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check({tag, " reset outputs"},
          {dbg_state, f_en, d_en, e_en, m_en, w_en, pc_en, mem_req, cc, stat, busy},
          {3'd0, 6'd0, 1'b0, 3'b100, 2'd0, 1'b0});
    check({tag, " reset counters"}, {cycle_count, instr_count}, 64'd0);
  endtask

  task automatic r(input logic rn, input logic [3:0] ic, input logic [3:0] fn,
                   input logic iv, input logic ie, input logic de, input logic mr,
                   input logic [2:0] ef, input int st, input logic mq,
                   input logic [2:0] c, input logic cd, input logic [1:0] sa);
    vec_t v;
    v.run = rn; v.icode = ic; v.ifun = fn; v.iv = iv; v.ierr = ie; v.derr = de;
    v.mrdy = mr; v.ef = ef; v.st = st; v.mreq = mq; v.cc = c; v.cnd = cd; v.stat = sa;
    vq.push_back(v);
  endtask

  // Non-memory instruction: six rows FETCH..PCUPD; cc_a is visible from MEMORY.
  // The MEMORY row drives dmem_error=1/mem_ready=0, which must be ignored.
  task automatic instr(input logic rn_first, input logic rn_last, input logic [3:0] ic,
                       input logic [3:0] fn, input logic [2:0] ef,
                       input logic [2:0] cc_b, input logic [2:0] cc_a, input logic cd);
    r(rn_first, ic, fn, 1, 0, 0, 0, ef, S_F, 0, cc_b, cd, 0);
    r(rn_first, ic, fn, 1, 0, 0, 0, ef, S_D, 0, cc_b, cd, 0);
    r(rn_first, ic, fn, 1, 0, 0, 0, ef, S_E, 0, cc_b, cd, 0);
    r(rn_first, ic, fn, 1, 0, 1, 0, ef, S_M, 0, cc_a, cd, 0);
    r(rn_first, ic, fn, 1, 0, 0, 0, ef, S_W, 0, cc_a, cd, 0);
    r(rn_last,  ic, fn, 1, 0, 0, 0, ef, S_P, 0, cc_a, cd, 0);
  endtask

  // driver + scoreboard: each row is driven after a falling edge and checked 1 ns later
  task automatic apply_rows(input string tag);
    logic [16:0] exp_v;
    logic [16:0] act_v;
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      run = vq[i].run; icode = vq[i].icode; ifun = vq[i].ifun;
      instr_valid = vq[i].iv; imem_error = vq[i].ierr;
      dmem_error = vq[i].derr; mem_ready = vq[i].mrdy;
      {e_zf, e_sf, e_of} = vq[i].ef;
      #1;
      exp_v = {vq[i].st[2:0], en_of(vq[i].st), vq[i].mreq, vq[i].cc, vq[i].cnd,
               vq[i].stat, (vq[i].st != S_I) && (vq[i].st != S_H)};
      act_v = {dbg_state, f_en, d_en, e_en, m_en, w_en, pc_en, mem_req, cc, cnd, stat, busy};
      check($sformatf("%s row %0d", tag, i), {47'd0, act_v}, {47'd0, exp_v});
    end
    vq.delete();
  endtask

  task automatic check_counts(input string tag, input logic [31:0] cyc, input logic [31:0] ins);
    @(negedge clk);
    #1;
    check({tag, " counters"}, {cycle_count, instr_count}, {cyc, ins});
  endtask

  initial begin
    logic exp100[8];
    logic exp011[8];
    exp100 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    exp011 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    rst = 1'b1;
    idle_inputs();

    // Three back-to-back irmovq: period 6, no idle gap.
    do_reset("t1");
    r(1, 4'h3, 4'h0, 1, 0, 0, 0, 3'b000, S_I, 0, 3'b100, 0, 0);
    for (int k = 0; k < 3; k++) instr(1, 1, 4'h3, 4'h0, 3'b011, 3'b100, 3'b100, 0);
    apply_rows("t1");
    check_counts("t1", 32'd18, 32'd3);
    check("t1 refetch", {61'd0, dbg_state}, 64'd1);

    // OPq/jl pairs and condition decode over two flag settings.
    do_reset("t2");
    r(1, 4'h6, 4'h1, 1, 0, 0, 0, 3'b010, S_I, 0, 3'b100, 0, 0);
    instr(1, 1, 4'h6, 4'h1, 3'b010, 3'b100, 3'b010, 0);
    instr(1, 1, 4'h7, 4'h2, 3'b001, 3'b010, 3'b010, 1);
    instr(1, 1, 4'h6, 4'h1, 3'b100, 3'b010, 3'b100, 0);
    instr(1, 0, 4'h7, 4'h2, 3'b010, 3'b100, 3'b100, 0);
    for (int k = 0; k < 8; k++) r(0, 4'h7, k[3:0], 1, 0, 0, 0, 3'b000, S_I, 0, 3'b100, exp100[k], 0);
    r(0, 4'h7, 4'hF, 1, 0, 0, 0, 3'b000, S_I, 0, 3'b100, 0, 0);
    r(0, 4'h2, 4'h0, 1, 0, 0, 0, 3'b000, S_I, 0, 3'b100, 1, 0);
    r(0, 4'h2, 4'h2, 1, 0, 0, 0, 3'b000, S_I, 0, 3'b100, 0, 0);
    r(0, 4'h3, 4'h0, 1, 0, 0, 0, 3'b000, S_I, 0, 3'b100, 0, 0);
    r(0, 4'h6, 4'h0, 1, 0, 0, 0, 3'b000, S_I, 0, 3'b100, 0, 0);
    r(1, 4'h6, 4'h0, 1, 0, 0, 0, 3'b011, S_I, 0, 3'b100, 0, 0);
    instr(1, 0, 4'h6, 4'h0, 3'b011, 3'b100, 3'b011, 0);
    for (int k = 0; k < 8; k++) r(0, 4'h7, k[3:0], 1, 0, 0, 0, 3'b100, S_I, 0, 3'b011, exp011[k], 0);
    r(0, 4'h2, 4'h6, 1, 0, 0, 0, 3'b000, S_I, 0, 3'b011, 1, 0);
    apply_rows("t2");
    check_counts("t2", 32'd30, 32'd5);

    // mrmovq with mem_ready on the 4th MEMORY cycle; dmem_error ignored while stalled.
    do_reset("t3");
    r(1, 4'h5, 4'h0, 1, 0, 0, 0, 3'b000, S_I, 0, 3'b100, 0, 0);
    r(1, 4'h5, 4'h0, 1, 0, 0, 0, 3'b000, S_F, 0, 3'b100, 0, 0);
    r(1, 4'h5, 4'h0, 1, 0, 0, 0, 3'b000, S_D, 0, 3'b100, 0, 0);
    r(1, 4'h5, 4'h0, 1, 0, 0, 0, 3'b010, S_E, 0, 3'b100, 0, 0);
    r(1, 4'h5, 4'h0, 1, 0, 0, 0, 3'b000, S_M, 1, 3'b100, 0, 0);
    r(1, 4'h5, 4'h0, 1, 0, 1, 0, 3'b000, S_M, 1, 3'b100, 0, 0);
    r(1, 4'h5, 4'h0, 1, 0, 0, 0, 3'b000, S_M, 1, 3'b100, 0, 0);
    r(1, 4'h5, 4'h0, 1, 0, 0, 1, 3'b000, S_M, 1, 3'b100, 0, 0);
    r(0, 4'h5, 4'h0, 1, 0, 0, 0, 3'b000, S_W, 0, 3'b100, 0, 0);
    r(0, 4'h5, 4'h0, 1, 0, 0, 0, 3'b000, S_P, 0, 3'b100, 0, 0);
    r(0, 4'h5, 4'h0, 1, 0, 0, 0, 3'b000, S_I, 0, 3'b100, 0, 0);
    apply_rows("t3");
    check_counts("t3", 32'd9, 32'd1);

    // rmmovq with a data-memory error on the completing cycle.
    do_reset("t4a");
    r(1, 4'h4, 4'h0, 1, 0, 0, 0, 3'b000, S_I, 0, 3'b100, 0, 0);
    r(1, 4'h4, 4'h0, 1, 0, 0, 0, 3'b000, S_F, 0, 3'b100, 0, 0);
    r(1, 4'h4, 4'h0, 1, 0, 0, 0, 3'b000, S_D, 0, 3'b100, 0, 0);
    r(1, 4'h4, 4'h0, 1, 0, 0, 0, 3'b000, S_E, 0, 3'b100, 0, 0);
    r(1, 4'h4, 4'h0, 1, 0, 1, 1, 3'b000, S_M, 1, 3'b100, 0, 0);
    for (int k = 0; k < 3; k++) r(1, 4'h4, 4'h0, 1, 0, 0, 1, 3'b011, S_H, 0, 3'b100, 0, 2);
    apply_rows("t4a");
    check_counts("t4a", 32'd4, 32'd0);

    // imem_error outranks an illegal instruction.
    do_reset("t4b");
    r(1, 4'h3, 4'h0, 1, 0, 0, 0, 3'b000, S_I, 0, 3'b100, 0, 0);
    r(1, 4'h3, 4'h0, 0, 1, 0, 0, 3'b000, S_F, 0, 3'b100, 0, 0);
    for (int k = 0; k < 2; k++) r(1, 4'h3, 4'h0, 1, 0, 0, 0, 3'b000, S_H, 0, 3'b100, 0, 2);
    apply_rows("t4b");
    check_counts("t4b", 32'd1, 32'd0);

    // Illegal instruction outranks halt.
    do_reset("t4c");
    r(1, 4'h0, 4'h0, 1, 0, 0, 0, 3'b000, S_I, 0, 3'b100, 0, 0);
    r(1, 4'h0, 4'h0, 0, 0, 0, 0, 3'b000, S_F, 0, 3'b100, 0, 0);
    for (int k = 0; k < 2; k++) r(1, 4'h0, 4'h0, 1, 0, 0, 0, 3'b000, S_H, 0, 3'b100, 0, 3);
    apply_rows("t4c");
    check_counts("t4c", 32'd1, 32'd0);

    // OPq then halt; reset out of HALT restores cc and counters.
    do_reset("t5");
    r(1, 4'h6, 4'h0, 1, 0, 0, 0, 3'b011, S_I, 0, 3'b100, 0, 0);
    instr(1, 1, 4'h6, 4'h0, 3'b011, 3'b100, 3'b011, 0);
    r(1, 4'h0, 4'h0, 1, 0, 0, 0, 3'b000, S_F, 0, 3'b011, 0, 0);
    for (int k = 0; k < 2; k++) r(1, 4'h0, 4'h0, 1, 0, 0, 0, 3'b000, S_H, 0, 3'b011, 0, 1);
    apply_rows("t5");
    check_counts("t5", 32'd7, 32'd1);
    do_reset("t5 from halt");

    // run dropped in EXECUTE: instruction completes, then parks in IDLE.
    r(1, 4'h3, 4'h0, 1, 0, 0, 0, 3'b000, S_I, 0, 3'b100, 0, 0);
    r(1, 4'h3, 4'h0, 1, 0, 0, 0, 3'b000, S_F, 0, 3'b100, 0, 0);
    r(1, 4'h3, 4'h0, 1, 0, 0, 0, 3'b000, S_D, 0, 3'b100, 0, 0);
    r(0, 4'h3, 4'h0, 1, 0, 0, 0, 3'b000, S_E, 0, 3'b100, 0, 0);
    r(0, 4'h3, 4'h0, 1, 0, 0, 0, 3'b000, S_M, 0, 3'b100, 0, 0);
    r(0, 4'h3, 4'h0, 1, 0, 0, 0, 3'b000, S_W, 0, 3'b100, 0, 0);
    r(0, 4'h3, 4'h0, 1, 0, 0, 0, 3'b000, S_P, 0, 3'b100, 0, 0);
    for (int k = 0; k < 2; k++) r(0, 4'h3, 4'h0, 1, 0, 0, 0, 3'b000, S_I, 0, 3'b100, 0, 0);
    apply_rows("t6");
    check_counts("t6", 32'd6, 32'd1);

    // Reset in the middle of a MEMORY stall.
    do_reset("t7");
    r(1, 4'h5, 4'h0, 1, 0, 0, 0, 3'b000, S_I, 0, 3'b100, 0, 0);
    r(1, 4'h5, 4'h0, 1, 0, 0, 0, 3'b000, S_F, 0, 3'b100, 0, 0);
    r(1, 4'h5, 4'h0, 1, 0, 0, 0, 3'b000, S_D, 0, 3'b100, 0, 0);
    r(1, 4'h5, 4'h0, 1, 0, 0, 0, 3'b000, S_E, 0, 3'b100, 0, 0);
    for (int k = 0; k < 2; k++) r(1, 4'h5, 4'h0, 1, 0, 0, 0, 3'b000, S_M, 1, 3'b100, 0, 0);
    apply_rows("t7");
    do_reset("t7 stall");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
